// File: rtl/ror_pkg.sv
// Shared ROR types: data widths, compactor FSM states and the point record.
package ror_pkg;

    localparam int N          = 16;
    localparam int IDX_W      = 16;
    localparam int MAX_POINTS = 2 ** IDX_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_DRAIN,
        ST_SCAN,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [N-1:0]     x;
        logic [N-1:0]     y;
        logic [N-1:0]     z;
        logic [IDX_W-1:0] idx;
    } point_t;

endpackage

// File: rtl/outlier_bitmap_ram.sv
// One-bit-per-point outlier flags: one write port, one registered read port.
module outlier_bitmap_ram
    import ror_pkg::*;
#(
    parameter int DEPTH  = MAX_POINTS,
    parameter int ADDR_W = IDX_W
) (
    input  logic              clock,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic              write_data,
    input  logic              read_en,
    input  logic [ADDR_W-1:0] read_addr,
    output logic              read_data
);

    logic flags [DEPTH];

    // NOTE: the array has no reset; every pass clears the range it uses before reading it.
    always_ff @(posedge clock) begin
        if (write_en)
            flags[write_addr] <= write_data;
        if (read_en)
            read_data <= flags[read_addr];
    end

endmodule

// File: rtl/outlier_drain_compactor.sv
// Drains outlier indices into a bitmap, then streams the surviving points in
// ascending index order through a 2-entry skid buffer.
module outlier_drain_compactor
    import ror_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [IDX_W:0]   point_cloud_size,
    input  logic             fifo_empty,
    output logic             read_fifo,
    input  logic [N-1:0]     outlier_idx,
    output logic             mem_rd,
    output logic [IDX_W-1:0] mem_addr,
    input  logic [N-1:0]     mem_x,
    input  logic [N-1:0]     mem_y,
    input  logic [N-1:0]     mem_z,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_x,
    output logic [N-1:0]     out_y,
    output logic [N-1:0]     out_z,
    output logic [IDX_W-1:0] out_idx,
    output logic [IDX_W:0]   kept_count,
    output logic [IDX_W:0]   outlier_count,
    output logic             err_range,
    output logic             busy,
    output logic             done
);

    state_t           state, state_next;
    logic [IDX_W:0]   size_q, clr_idx, scan_idx;
    logic             pop_q, rd_q, flag_rd;
    logic [IDX_W-1:0] rd_idx_q;
    point_t           skid_head, skid_tail, new_point;
    logic [1:0]       skid_cnt, skid_cnt_after;
    logic             start_ok, in_range, push, pop, room;
    logic             bm_we, bm_wdata;
    logic [IDX_W-1:0] bm_waddr;

    assign start_ok  = start && (state == ST_IDLE || state == ST_DONE);
    assign in_range  = (IDX_W+1)'(outlier_idx) < size_q;
    assign read_fifo = (state == ST_DRAIN) && !fifo_empty;

    // A read in flight that will be kept already owns a slot for next cycle.
    assign push           = rd_q && !flag_rd;
    assign pop            = out_valid && out_ready;
    assign skid_cnt_after = skid_cnt - 2'(pop);
    assign room           = (skid_cnt_after + 2'(push)) < 2'd2;
    assign mem_rd         = (state == ST_SCAN) && (scan_idx < size_q) && room;
    assign mem_addr       = scan_idx[IDX_W-1:0];

    assign bm_we    = (state == ST_CLEAR) || ((state == ST_DRAIN) && pop_q && in_range);
    assign bm_waddr = (state == ST_CLEAR) ? clr_idx[IDX_W-1:0] : outlier_idx[IDX_W-1:0];
    assign bm_wdata = (state != ST_CLEAR);

    assign new_point = '{x: mem_x, y: mem_y, z: mem_z, idx: rd_idx_q};
    assign out_valid = (skid_cnt != 2'd0);
    assign out_x     = skid_head.x;
    assign out_y     = skid_head.y;
    assign out_z     = skid_head.z;
    assign out_idx   = skid_head.idx;
    assign busy      = (state == ST_CLEAR) || (state == ST_DRAIN) || (state == ST_SCAN);
    assign done      = (state == ST_DONE);

    outlier_bitmap_ram u_bitmap (
        .clock      (clock),
        .write_en   (bm_we),
        .write_addr (bm_waddr),
        .write_data (bm_wdata),
        .read_en    (mem_rd),
        .read_addr  (mem_addr),
        .read_data  (flag_rd)
    );

    always_ff @(posedge clock) begin
        if (!reset)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        // NOTE: default assigned before the case so no path infers a latch.
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE:
                if (start)
                    state_next = (point_cloud_size == '0) ? ST_DRAIN : ST_CLEAR;
            ST_CLEAR:
                if ((clr_idx + 1'b1) == size_q)
                    state_next = ST_DRAIN;
            ST_DRAIN:
                if (fifo_empty && !pop_q)
                    state_next = ST_SCAN;
            ST_SCAN:
                if ((scan_idx == size_q) && !rd_q && (skid_cnt == 2'd0))
                    state_next = ST_DONE;
            default:
                state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset) begin
            size_q        <= '0;
            clr_idx       <= '0;
            scan_idx      <= '0;
            pop_q         <= 1'b0;
            rd_q          <= 1'b0;
            rd_idx_q      <= '0;
            kept_count    <= '0;
            outlier_count <= '0;
            err_range     <= 1'b0;
        end else begin
            pop_q <= read_fifo;
            rd_q  <= mem_rd;
            if (mem_rd)
                rd_idx_q <= mem_addr;
            if (start_ok) begin
                size_q        <= point_cloud_size;
                clr_idx       <= '0;
                scan_idx      <= '0;
                kept_count    <= '0;
                outlier_count <= '0;
                err_range     <= 1'b0;
            end else begin
                if (state == ST_CLEAR)
                    clr_idx <= clr_idx + 1'b1;
                if ((state == ST_DRAIN) && pop_q) begin
                    if (in_range)
                        outlier_count <= outlier_count + 1'b1;
                    else
                        err_range <= 1'b1;
                end
                if (mem_rd)
                    scan_idx <= scan_idx + 1'b1;
                if (pop)
                    kept_count <= kept_count + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            skid_cnt  <= 2'd0;
            skid_head <= '0;
            skid_tail <= '0;
        end else begin
            if (pop)
                skid_head <= skid_tail;
            if (push) begin
                if (skid_cnt_after == 2'd0)
                    skid_head <= new_point;
                else
                    skid_tail <= new_point;
            end
            skid_cnt <= skid_cnt_after + 2'(push);
        end
    end

endmodule

// File: tb/tb_outlier_drain_compactor.sv
// Directed bench for outlier_drain_compactor: FIFO and point-memory models plus
// an expected-index scoreboard checked on every output handshake.
module tb_outlier_drain_compactor;
    import ror_pkg::*;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [IDX_W:0]   point_cloud_size = '0;
    logic             fifo_empty = 1'b1;
    logic             read_fifo;
    logic [N-1:0]     outlier_idx = '0;
    logic             mem_rd;
    logic [IDX_W-1:0] mem_addr;
    logic [N-1:0]     mem_x = '0, mem_y = '0, mem_z = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [N-1:0]     out_x, out_y, out_z;
    logic [IDX_W-1:0] out_idx;
    logic [IDX_W:0]   kept_count, outlier_count;
    logic             err_range, busy, done;

    int   errors = 0;
    int   checks = 0;
    int   fifo_q[$];
    int   exp_q[$];
    bit   model_bm [16];
    int   model_size, model_outl;
    bit   model_err;
    bit   ready_toggle = 1'b0;
    bit   valid_seen, rdfifo_seen, prev_stall;
    logic [63:0] prev_out;
    int   lat_rd, lat_done, lat_m2v;

    outlier_drain_compactor dut (
        .clock            (clock),
        .reset            (reset),
        .start            (start),
        .point_cloud_size (point_cloud_size),
        .fifo_empty       (fifo_empty),
        .read_fifo        (read_fifo),
        .outlier_idx      (outlier_idx),
        .mem_rd           (mem_rd),
        .mem_addr         (mem_addr),
        .mem_x            (mem_x),
        .mem_y            (mem_y),
        .mem_z            (mem_z),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_x            (out_x),
        .out_y            (out_y),
        .out_z            (out_z),
        .out_idx          (out_idx),
        .kept_count       (kept_count),
        .outlier_count    (outlier_count),
        .err_range        (err_range),
        .busy             (busy),
        .done             (done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Outlier FIFO: data appears on outlier_idx the cycle after a pop.
    always @(posedge clock) begin
        if (read_fifo) begin
            if (fifo_q.size() > 0)
                outlier_idx <= 16'(fifo_q.pop_front());
            fifo_empty <= (fifo_q.size() == 0);
        end
    end

    // Point memory holds (k, k+16, k+32) at address k.
    always @(posedge clock) begin
        if (mem_rd) begin
            mem_x <= mem_addr;
            mem_y <= mem_addr + 16'd16;
            mem_z <= mem_addr + 16'd32;
        end
    end

    always @(negedge clock) out_ready = ready_toggle ? ~out_ready : 1'b1;

    always @(negedge clock) begin
        #1;
        if (reset) begin
            if (prev_stall) begin
                check("stall_valid", 64'(out_valid), 64'd1);
                check("stall_data", {out_x, out_y, out_z, out_idx}, prev_out);
            end
            if (out_valid) valid_seen = 1'b1;
            if (read_fifo) rdfifo_seen = 1'b1;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 64'(exp_q.size()), 64'd1);
                end else begin
                    int k;
                    k = exp_q.pop_front();
                    check("out_idx", 64'(out_idx), 64'(k));
                    check("out_xyz", 64'({out_x, out_y, out_z}), 64'({16'(k), 16'(k + 16), 16'(k + 32)}));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = {out_x, out_y, out_z, out_idx};
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic begin_pass(input int s, input bit toggle);
        model_size   = s;
        model_outl   = 0;
        model_err    = 1'b0;
        ready_toggle = toggle;
        for (int i = 0; i < 16; i++) model_bm[i] = 1'b0;
    endtask

    task automatic add_outlier(input int v);
        fifo_q.push_back(v);
        fifo_empty = 1'b0;
        if (v < model_size) begin
            model_bm[v] = 1'b1;
            model_outl++;
        end else begin
            model_err = 1'b1;
        end
    endtask

    task automatic launch();
        int first_mem, first_valid;
        for (int k = 0; k < model_size; k++)
            if (!model_bm[k]) exp_q.push_back(k);
        valid_seen  = 1'b0;
        rdfifo_seen = 1'b0;
        first_mem   = -1;
        first_valid = -1;
        lat_rd      = -1;
        lat_done    = -1;
        @(negedge clock);
        start            = 1'b1;
        point_cloud_size = (IDX_W+1)'(model_size);
        for (int c = 1; c <= 400; c++) begin
            @(negedge clock);
            start = 1'b0;
            #2;
            if (read_fifo && lat_rd < 0) lat_rd = c;
            if (mem_rd && first_mem < 0) first_mem = c;
            if (out_valid && first_valid < 0) first_valid = c;
            if (done) begin
                lat_done = c;
                break;
            end
        end
        lat_m2v = first_valid - first_mem;
    endtask

    task automatic finish_pass(input string name);
        int uniq;
        uniq = 0;
        for (int i = 0; i < 16; i++) uniq += int'(model_bm[i]);
        check({name, "_done"}, 64'(done), 64'd1);
        check({name, "_busy"}, 64'(busy), 64'd0);
        check({name, "_leftover"}, 64'(exp_q.size()), 64'd0);
        check({name, "_kept"}, 64'(kept_count), 64'(model_size - uniq));
        check({name, "_outliers"}, 64'(outlier_count), 64'(model_outl));
        check({name, "_err_range"}, 64'(err_range), 64'(model_err));
        exp_q.delete();
        ready_toggle = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clock);
        #2;
        check("reset_outputs",
              {read_fifo, mem_rd, mem_addr, out_valid, out_idx, kept_count, outlier_count, err_range, busy, done},
              '0);
        check("reset_out_xyz", 64'({out_x, out_y, out_z}), 64'd0);
        reset = 1'b1;

        begin_pass(8, 1'b0); add_outlier(2); add_outlier(5);
        launch();
        check("t1_rd_latency", 64'(lat_rd), 64'd9);
        check("t1_mem_to_valid", 64'(lat_m2v), 64'd2);
        finish_pass("t1");

        begin_pass(4, 1'b0); add_outlier(3); add_outlier(3); add_outlier(0);
        launch();
        finish_pass("t2");

        begin_pass(8, 1'b0); add_outlier(10); add_outlier(4);
        launch();
        finish_pass("t3");

        begin_pass(16, 1'b1);
        launch();
        finish_pass("t4");

        begin_pass(0, 1'b0);
        launch();
        check("t5_done_within_3", 64'(lat_done >= 1 && lat_done <= 3), 64'd1);
        check("t5_no_valid", 64'(valid_seen), 64'd0);
        check("t5_no_read_fifo", 64'(rdfifo_seen), 64'd0);
        finish_pass("t5");

        begin_pass(0, 1'b0); add_outlier(3);
        launch();
        check("t5b_rd_latency", 64'(lat_rd), 64'd1);
        finish_pass("t5b");

        // Pass 1 interrupted by reset during SCAN.
        begin_pass(8, 1'b0); add_outlier(1);
        for (int k = 0; k < model_size; k++)
            if (!model_bm[k]) exp_q.push_back(k);
        @(negedge clock);
        start            = 1'b1;
        point_cloud_size = 17'd8;
        for (int c = 0; c < 200; c++) begin
            @(negedge clock);
            start = 1'b0;
            #2;
            if (mem_rd) break;
        end
        check("t6_reached_scan", 64'(mem_rd), 64'd1);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        exp_q.delete();
        @(negedge clock);
        #2;
        check("t6_reset_outputs",
              {read_fifo, mem_rd, mem_addr, out_valid, out_idx, kept_count, outlier_count, err_range, busy, done},
              '0);
        check("t6_reset_out_xyz", 64'({out_x, out_y, out_z}), 64'd0);
        reset = 1'b1;

        begin_pass(4, 1'b0);
        launch();
        finish_pass("t6_pass2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
